// File: rtl/alu_dispatcher.sv
// Command queue and single-outstanding issue stage in front of the fixed-point ALU.
// Results are captured into a small FIFO; issue is credit-gated so the ALU never overruns it.
module alu_dispatcher #(
    parameter int INST_W    = 4,
    parameter int DATA_W    = 16,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    input  logic [INST_W-1:0]            i_s_inst,
    input  logic [DATA_W-1:0]            i_s_data_a,
    input  logic [DATA_W-1:0]            i_s_data_b,
    output logic                         o_alu_valid,
    output logic [INST_W-1:0]            o_alu_inst,
    output logic [DATA_W-1:0]            o_alu_data_a,
    output logic [DATA_W-1:0]            o_alu_data_b,
    input  logic                         i_alu_busy,
    input  logic                         i_alu_out_valid,
    input  logic [DATA_W-1:0]            i_alu_data,
    output logic                         o_m_valid,
    input  logic                         i_m_ready,
    output logic [DATA_W-1:0]            o_m_data,
    output logic [INST_W-1:0]            o_m_inst,
    output logic [$clog2(CMD_DEPTH):0]   o_cmd_count,
    output logic                         o_err
);
    localparam int CA = $clog2(CMD_DEPTH);
    localparam int RA = $clog2(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] data;
    } res_t;

    state_t            state;
    cmd_t              cmd_mem [CMD_DEPTH];
    logic [CA-1:0]     cmd_wp, cmd_rp;
    logic [CA:0]       cmd_cnt;
    res_t              res_mem [RES_DEPTH];
    logic [RA-1:0]     res_wp, res_rp;
    logic [RA:0]       res_cnt;
    logic [INST_W-1:0] tag;

    logic cmd_push, cmd_empty, inflight, credit, want_issue, issue, capture, m_pop;

    assign o_s_ready   = (cmd_cnt != (CA+1)'(CMD_DEPTH));
    assign cmd_push    = i_s_valid & o_s_ready;
    assign cmd_empty   = (cmd_cnt == '0);
    assign o_cmd_count = cmd_cnt;

    // Outstanding op counts against result space so a capture always finds room.
    assign inflight   = (state != S_IDLE);
    assign credit     = ({1'b0, res_cnt} + {{(RA+1){1'b0}}, inflight}) < (RA+2)'(RES_DEPTH);
    assign want_issue = (state == S_IDLE) & ~cmd_empty & credit;
    assign issue      = want_issue & ~i_alu_busy;
    assign capture    = (state == S_WAIT) & i_alu_out_valid;

    assign o_m_valid = (res_cnt != '0);
    assign m_pop     = o_m_valid & i_m_ready;
    assign o_m_data  = o_m_valid ? res_mem[res_rp].data : '0;
    assign o_m_inst  = o_m_valid ? res_mem[res_rp].inst : '0;

    always_ff @(posedge i_clk) begin
        if (cmd_push)
            cmd_mem[cmd_wp] <= '{inst: i_s_inst, a: i_s_data_a, b: i_s_data_b};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (issue)    cmd_rp <= cmd_rp + 1'b1;
            case ({cmd_push, issue})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // Operand registers hold between pulses; the ALU re-latches them on each valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            o_alu_valid  <= 1'b0;
            o_alu_inst   <= '0;
            o_alu_data_a <= '0;
            o_alu_data_b <= '0;
            tag          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_alu_valid <= 1'b0;
                    if (issue) begin
                        state        <= S_ISSUE;
                        o_alu_valid  <= 1'b1;
                        o_alu_inst   <= cmd_mem[cmd_rp].inst;
                        o_alu_data_a <= cmd_mem[cmd_rp].a;
                        o_alu_data_b <= cmd_mem[cmd_rp].b;
                        tag          <= cmd_mem[cmd_rp].inst;
                    end
                end
                S_ISSUE: begin
                    state       <= S_WAIT;
                    o_alu_valid <= 1'b0;
                end
                S_WAIT: begin
                    o_alu_valid <= 1'b0;
                    if (i_alu_out_valid) state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    o_alu_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (capture)
            res_mem[res_wp] <= '{inst: tag, data: i_alu_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (capture) res_wp <= res_wp + 1'b1;
            if (m_pop)   res_rp <= res_rp + 1'b1;
            case ({capture, m_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    // Sticky: stray result outside S_WAIT, or ALU busy when an issue was due.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_err <= 1'b0;
        else if ((i_alu_out_valid && state != S_WAIT) || (want_issue && i_alu_busy))
            o_err <= 1'b1;
    end
endmodule

// File: tb/tb_alu_dispatcher.sv
// Scoreboard bench for alu_dispatcher: directed vectors, behavioural ALU responder,
// issue/result monitors compare against queued expectations.
module tb_alu_dispatcher;
    typedef struct packed {
        logic [3:0]  inst;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } vec_t;

    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        i_s_valid = 1'b0, o_s_ready;
    logic [3:0]  i_s_inst = '0;
    logic [15:0] i_s_data_a = '0, i_s_data_b = '0;
    logic        o_alu_valid;
    logic [3:0]  o_alu_inst;
    logic [15:0] o_alu_data_a, o_alu_data_b;
    logic        i_alu_busy = 1'b0, alu_ov_m = 1'b0, spur = 1'b0, i_alu_out_valid;
    logic [15:0] i_alu_data = '0;
    logic        o_m_valid, i_m_ready = 1'b1;
    logic [15:0] o_m_data;
    logic [3:0]  o_m_inst;
    logic [2:0]  o_cmd_count;
    logic        o_err;

    assign i_alu_out_valid = alu_ov_m | spur;

    alu_dispatcher #(.INST_W(4), .DATA_W(16), .CMD_DEPTH(4), .RES_DEPTH(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_inst(i_s_inst),
        .i_s_data_a(i_s_data_a), .i_s_data_b(i_s_data_b),
        .o_alu_valid(o_alu_valid), .o_alu_inst(o_alu_inst),
        .o_alu_data_a(o_alu_data_a), .o_alu_data_b(o_alu_data_b),
        .i_alu_busy(i_alu_busy), .i_alu_out_valid(i_alu_out_valid), .i_alu_data(i_alu_data),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_inst(o_m_inst),
        .o_cmd_count(o_cmd_count), .o_err(o_err)
    );

    vec_t sb_q[$];
    vec_t iss_q[$];
    int   n_vec = 0, n_err = 0, cyc = 0, phase = 0, last_acc = 0;
    int   issue_cnt = 0, max_cnt = 0, last_pop = 0;
    bit   saw_full = 0, rej_pending = 0, have_last = 0, prev_av = 0, prev_mv = 0;

    initial forever #5 i_clk = ~i_clk;
    initial forever begin @(posedge i_clk); cyc++; end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU responder: valid seen in cycle t+1 -> busy t+2, result t+3, idle t+4.
    initial begin
        logic [15:0] r;
        int st;
        st = 0;
        r  = '0;
        forever begin
            @(posedge i_clk); #1;
            if (!i_rst_n) begin
                st = 0; i_alu_busy = 1'b0; alu_ov_m = 1'b0; i_alu_data = '0;
            end else begin
                case (st)
                    0: if (o_alu_valid) begin
                        r  = alu_f(o_alu_inst, o_alu_data_a, o_alu_data_b);
                        st = 1;
                    end
                    1: begin i_alu_busy = 1'b1; st = 2; end
                    2: begin alu_ov_m = 1'b1; i_alu_data = r; st = 3; end
                    default: begin alu_ov_m = 1'b0; i_alu_busy = 1'b0; st = 0; end
                endcase
            end
        end
    end

    // Monitor: samples on the falling edge, inputs are driven just after the rising edge.
    initial forever begin
        vec_t v;
        @(negedge i_clk);
        if (!i_rst_n) begin
            prev_av = 0; prev_mv = 0; rej_pending = 0;
        end else begin
            if (o_alu_valid) begin
                issue_cnt++;
                chk("no_b2b_issue", 32'(prev_av), 32'd0);
                if (iss_q.size() == 0) fail("unexpected_issue");
                else begin
                    v = iss_q.pop_front();
                    chk("alu_inst", 32'(o_alu_inst), 32'(v.inst));
                    chk("alu_a", 32'(o_alu_data_a), 32'(v.a));
                    chk("alu_b", 32'(o_alu_data_b), 32'(v.b));
                end
                if (phase == 1) chk("issue_latency", 32'(cyc), 32'(last_acc + 1));
            end
            if (o_m_valid && i_m_ready) begin
                if (sb_q.size() == 0) fail("unexpected_result");
                else begin
                    v = sb_q.pop_front();
                    chk("m_data", 32'(o_m_data), 32'(v.res));
                    chk("m_inst", 32'(o_m_inst), 32'(v.inst));
                end
                if (phase == 2) begin
                    if (have_last) chk("result_spacing", 32'(cyc - last_pop), 32'd4);
                    have_last = 1;
                    last_pop  = cyc;
                end
            end
            if (phase == 1 && o_m_valid && !prev_mv)
                chk("result_latency", 32'(cyc), 32'(last_acc + 4));
            if (phase == 2) begin
                if (rej_pending) begin
                    chk("rejected_push_occupancy", 32'(o_cmd_count), 32'd3);
                    rej_pending = 0;
                end
                if (i_s_valid && !o_s_ready) begin saw_full = 1; rej_pending = 1; end
                if (int'(o_cmd_count) > max_cnt) max_cnt = int'(o_cmd_count);
            end
            prev_av = o_alu_valid;
            prev_mv = o_m_valid;
        end
    end

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res);
        vec_t v;
        bit   ok;
        v  = '{inst: op, a: a, b: b, res: res};
        ok = 0;
        i_s_valid = 1'b1; i_s_inst = op; i_s_data_a = a; i_s_data_b = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge i_clk);
            if (o_s_ready) begin
                ok = 1;
                last_acc = cyc + 1;
                sb_q.push_back(v);
                iss_q.push_back(v);
            end
            @(posedge i_clk); #1;
        end
        i_s_valid = 1'b0;
        if (!ok) fail("push_timeout");
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge i_clk);
            done = (sb_q.size() == 0) && (iss_q.size() == 0) && (o_cmd_count == 3'd0) &&
                   !o_m_valid && !i_alu_busy;
        end
        chk(nm, 32'(done), 32'd1);
        @(posedge i_clk); #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_s_ready"},   32'(o_s_ready), 32'd1);
        chk({p, "_alu_valid"}, 32'(o_alu_valid), 32'd0);
        chk({p, "_alu_inst"},  32'(o_alu_inst), 32'd0);
        chk({p, "_alu_a"},     32'(o_alu_data_a), 32'd0);
        chk({p, "_alu_b"},     32'(o_alu_data_b), 32'd0);
        chk({p, "_m_valid"},   32'(o_m_valid), 32'd0);
        chk({p, "_m_data"},    32'(o_m_data), 32'd0);
        chk({p, "_m_inst"},    32'(o_m_inst), 32'd0);
        chk({p, "_cmd_count"}, 32'(o_cmd_count), 32'd0);
        chk({p, "_err"},       32'(o_err), 32'd0);
    endtask

    initial begin
        bit found;
        step(3);
        @(negedge i_clk);
        chk_reset("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        step(2);

        // Single ADD with latency checks
        phase = 1;
        push(4'd0, 16'h0400, 16'h0800, 16'h0C00);
        drain("drain_single");

        // Burst of 6, consumer always ready
        phase = 2; have_last = 0; saw_full = 0; max_cnt = 0;
        push(4'd0, 16'h0100, 16'h0200, 16'h0300);
        push(4'd1, 16'h0800, 16'h0400, 16'h0400);
        push(4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0);
        push(4'd3, 16'h1200, 16'h0034, 16'h1234);
        push(4'd1, 16'h0000, 16'h0400, 16'hFC00);
        push(4'd0, 16'h7C00, 16'h0800, 16'h8400);
        drain("drain_burst");
        chk("burst_saw_full", 32'(saw_full), 32'd1);
        chk("burst_max_count", 32'(max_cnt), 32'd4);

        // Back-pressure: only RES_DEPTH ops may be stored or in flight
        phase = 3; i_m_ready = 1'b0; issue_cnt = 0;
        push(4'd4, 16'hAAAA, 16'h5555, 16'hFFFF);
        push(4'd0, 16'h0001, 16'h0001, 16'h0002);
        push(4'd2, 16'h1234, 16'h00FF, 16'h0034);
        push(4'd3, 16'h8000, 16'h0001, 16'h8001);
        step(30);
        chk("bp_issue_count", 32'(issue_cnt), 32'd2);
        chk("bp_m_valid", 32'(o_m_valid), 32'd1);
        chk("bp_cmd_count", 32'(o_cmd_count), 32'd2);
        i_m_ready = 1'b1;
        drain("drain_backpressure");
        chk("bp_total_issues", 32'(issue_cnt), 32'd4);

        // Capture and consumer pop in the same cycle
        phase = 4; i_m_ready = 1'b0;
        push(4'd1, 16'h0C00, 16'h0400, 16'h0800);
        push(4'd0, 16'hFFFF, 16'h0001, 16'h0000);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge i_clk);
            found = o_m_valid && i_alu_busy && !i_alu_out_valid;
        end
        chk("sim_setup", 32'(found), 32'd1);
        @(posedge i_clk); #1; i_m_ready = 1'b1;
        @(posedge i_clk); #1; i_m_ready = 1'b0;
        @(negedge i_clk);
        chk("sim_occupancy_kept", 32'(o_m_valid), 32'd1);
        @(posedge i_clk); #1; i_m_ready = 1'b1;
        @(posedge i_clk); #1; i_m_ready = 1'b0;
        @(negedge i_clk);
        chk("sim_occupancy_one", 32'(o_m_valid), 32'd0);
        i_m_ready = 1'b1;
        drain("drain_simultaneous");

        // Spurious result in S_IDLE, then reset while in S_WAIT
        phase = 5;
        @(negedge i_clk);
        chk("err_clear_before", 32'(o_err), 32'd0);
        @(posedge i_clk); #1; spur = 1'b1;
        @(posedge i_clk); #1; spur = 1'b0;
        @(negedge i_clk);
        chk("err_set", 32'(o_err), 32'd1);
        chk("spurious_not_written", 32'(o_m_valid), 32'd0);
        step(1);
        push(4'd0, 16'h0400, 16'h0400, 16'h0800);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge i_clk);
            found = i_alu_busy;
        end
        chk("reach_wait", 32'(found), 32'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        sb_q.delete();
        iss_q.delete();
        @(negedge i_clk);
        chk_reset("midreset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        step(2);
        push(4'd5, 16'h00FF, 16'h0F0F, 16'h0FF0);
        drain("drain_after_reset");
        chk("err_after_recovery", 32'(o_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_dispatcher.md
# alu_dispatcher

Command-queue and issue stage that sits directly upstream of the fixed-point ALU.
- Buffers host commands (instruction plus two operands) in a small FIFO.
- Issues them one at a time into the ALU's single-pulse valid/busy interface.
- Captures each ALU result into a result FIFO drained by a downstream valid/ready consumer.
- Stalls issue when no result space is guaranteed, so the ALU, which cannot be back-pressured, never has a result dropped.

## Interface
- INST_W, 4, instruction width
- DATA_W, 16, operand/result width (Q6.10 signed)
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RES_DEPTH, 2, result FIFO entries (power of 2, ≥2)
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_s_valid  in  1  host command valid
- o_s_ready  out  1  command FIFO not full
- i_s_inst  in  INST_W  host instruction
- i_s_data_a  in  DATA_W  host operand A
- i_s_data_b  in  DATA_W  host operand B
- o_alu_valid  out  1  one-cycle issue pulse to the ALU
- o_alu_inst  out  INST_W  issued instruction, registered
- o_alu_data_a  out  DATA_W  issued operand A, registered
- o_alu_data_b  out  DATA_W  issued operand B, registered
- i_alu_busy  in  1  ALU busy
- i_alu_out_valid  in  1  ALU result valid, one cycle
- i_alu_data  in  DATA_W  ALU result
- o_m_valid  out  1  result FIFO not empty
- i_m_ready  in  1  consumer accepts the head result
- o_m_data  out  DATA_W  head result
- o_m_inst  out  INST_W  instruction that produced the head result
- o_cmd_count  out  clog2(CMD_DEPTH)+1  command FIFO occupancy
- o_err  out  1  sticky protocol error

## Operation
- **Command FIFO**
  - Push on i_s_valid & o_s_ready.
  - o_s_ready = ~full, taken from registered occupancy, with no same-cycle pop-through.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
- **FSM states:** S_IDLE, S_ISSUE, S_WAIT.
  - S_IDLE → S_ISSUE when the command FIFO is non-empty, i_alu_busy = 0 and credit is available.
  - credit = (result FIFO occupancy + in-flight) < RES_DEPTH.
  - On this transition, pop the command FIFO and register its head onto o_alu_inst/data_a/data_b.
  - The instruction is also kept in a tag register for o_m_inst.
  - S_ISSUE: o_alu_valid = 1 for exactly this one cycle. Next state is unconditionally S_WAIT.
  - S_WAIT: o_alu_valid = 0. On i_alu_out_valid, write {tag, i_alu_data} into the result FIFO and go to S_IDLE.
- **In-flight:** in-flight = 1 in S_ISSUE and S_WAIT, 0 in S_IDLE. At most one operation is ever outstanding.
- **ALU operand hold:** o_alu_* hold their value until the next issue, because the ALU re-latches operands on every valid pulse.
- **Result FIFO**
  - Pop on o_m_valid & i_m_ready.
  - Capture and pop in the same cycle are both legal.
  - Credit guarantees that a capture never meets a full FIFO.
- **o_err** sets and stays set until reset on either of:
  - i_alu_out_valid while in S_IDLE or S_ISSUE; the data is discarded.
  - i_alu_busy = 1 while in S_IDLE for a cycle in which the FSM would otherwise issue.
- The dispatcher performs no arithmetic; results pass through unchanged.

## Timing
- **Reset values:** o_s_ready = 1; o_alu_valid = 0; o_alu_inst/data_a/data_b = 0; o_m_valid = 0; o_m_data = 0; o_m_inst = 0; o_cmd_count = 0; o_err = 0; FSM in S_IDLE; both FIFOs empty.
- **Reset mid-operation:** clears everything, including any in-flight result. The ALU shares i_rst_n and resets with the dispatcher.
- **Latency, command accepted at edge t into an empty FIFO with an idle ALU:**
  - o_alu_valid high in cycle t+1.
  - ALU busy in t+2.
  - i_alu_out_valid in t+3.
  - o_m_valid high in t+4.
- **Throughput:** next issue pulse at t+5, giving 4 cycles per operation. Back-to-back valid pulses are never generated.
- **Full FIFO:** with CMD_DEPTH commands queued, o_s_ready = 0. It returns to 1 the cycle after the pop edge.
- **Back-pressure:** with i_m_ready held low, issue stops once RES_DEPTH results are stored or in flight. Issue resumes in the cycle after credit frees.

## Test plan
- **Single ADD:** reset, then push inst 0, a = 16'h0400, b = 16'h0800 → o_alu_valid one cycle at t+1. Model the ALU returning 16'h0C00 at t+3 → o_m_valid at t+4, o_m_data = 16'h0C00, o_m_inst = 0.
- **Burst of 6:** 6 commands pushed every cycle with i_m_ready = 1 → o_s_ready low after 4 are queued. The 6 results arrive in order at 4-cycle spacing, and o_cmd_count never exceeds 4.
- **Back-pressure:** i_m_ready = 0 with 4 commands queued → exactly 2 issue pulses and 2 results held. Raise i_m_ready → remaining 2 issue, and all 4 drain in order.
- **Simultaneous events:** push while the FIFO holds 4 and the dispatcher pops in the same cycle → push rejected (o_s_ready was 0), occupancy 3.
- **Simultaneous result events:** m-pop in the same cycle as a capture → occupancy unchanged, order preserved.
- **Protocol error and reset:** spurious i_alu_out_valid in S_IDLE → o_err = 1, no result written. Assert i_rst_n low while in S_WAIT → all outputs return to reset values, and o_err clears.
